// File: rtl/scan_mux.sv
// Registered N-channel multiplexer with manual select and auto-scan modes.
// In scan mode an internal channel counter dwells dwell+1 enabled cycles per channel.
module scan_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          ch,
    output logic                      valid,
    output logic                      wrap
);

    localparam logic [SEL_W:0]   CH_N    = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0]   y_q,     y_d;
    logic [SEL_W-1:0]   ch_q,    ch_d;
    logic [DWELL_W-1:0] cnt_q,   cnt_d;
    logic               valid_q, valid_d;
    logic               wrap_q,  wrap_d;
    logic [SEL_W-1:0]   nxt;

    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d,
                                              input logic [SEL_W-1:0]          idx);
        pick = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) pick = d[k*WIDTH +: WIDTH];
        end
    endfunction

    always_comb begin
        nxt     = ch_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        y_d     = y_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        if (en) begin
            if (!mode) begin
                // Out-of-range requests keep the current channel.
                if ({1'b0, sel} < CH_N) nxt = sel;
                cnt_d = '0;
            end else if (cnt_q == dwell) begin
                cnt_d = '0;
                if (ch_q == CH_LAST) begin
                    nxt    = '0;
                    wrap_d = 1'b1;
                end else begin
                    nxt = ch_q + SEL_W'(1);
                end
            end else begin
                cnt_d = cnt_q + DWELL_W'(1);
            end
            ch_d    = nxt;
            y_d     = pick(din, nxt);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            y_q     <= y_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y     = y_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 4-channel instance for the main flow and a
// 3-channel instance for out-of-range select and short-rotation wrap.
module tb_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        en_a = 1'b0, mode_a = 1'b0;
    logic [1:0]  sel_a = '0;
    logic [3:0]  dwell_a = '0;
    logic [15:0] din_a = '0;
    logic [3:0]  y_a;
    logic [1:0]  ch_a;
    logic        valid_a, wrap_a;

    logic        en_b = 1'b0, mode_b = 1'b0;
    logic [1:0]  sel_b = '0;
    logic [3:0]  dwell_b = '0;
    logic [11:0] din_b = '0;
    logic [3:0]  y_b;
    logic [1:0]  ch_b;
    logic        valid_b, wrap_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL_W(4)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .sel(sel_a), .dwell(dwell_a),
        .din(din_a), .y(y_a), .ch(ch_a), .valid(valid_a), .wrap(wrap_a)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL_W(4)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .sel(sel_b), .dwell(dwell_b),
        .din(din_b), .y(y_b), .ch(ch_b), .valid(valid_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int sweep[8] = '{0, 1, 2, 3, 3, 2, 1, 0};

    initial begin
        #2;
        check("rst_y", y_a, 0);
        check("rst_ch", ch_a, 0);
        check("rst_valid", valid_a, 0);
        rst = 1'b0;
        din_a = {4'd4, 4'd3, 4'd2, 4'd1};

        // No enabled edge yet: outputs stay cleared despite din.
        step();
        check("pre_en_y", y_a, 0);
        check("pre_en_valid", valid_a, 0);

        en_a = 1'b1; sel_a = 2'd3;
        step();
        check("pre_rst_y", y_a, 4);

        // Asynchronous reset in the middle of the high phase.
        #3 rst = 1'b1;
        #1;
        check("async_rst_y", y_a, 0);
        check("async_rst_ch", ch_a, 0);
        check("async_rst_valid", valid_a, 0);
        #2 rst = 1'b0;
        sel_a = 2'd2;
        step();
        check("first_y", y_a, 3);
        check("first_ch", ch_a, 2);
        check("first_valid", valid_a, 1);

        for (int i = 0; i < 8; i++) begin
            sel_a = 2'(sweep[i]);
            step();
            check("sweep1_y", y_a, 32'(sweep[i] + 1));
            check("sweep1_ch", ch_a, 32'(sweep[i]));
        end
        din_a = {4'd8, 4'd7, 4'd6, 4'd5};
        for (int i = 0; i < 8; i++) begin
            sel_a = 2'(sweep[i]);
            step();
            check("sweep2_y", y_a, 32'(sweep[i] + 5));
        end

        // Scan with dwell=2 starting from ch 0 (already selected).
        din_a = {4'd4, 4'd3, 4'd2, 4'd1};
        sel_a = 2'd0;
        step();
        mode_a = 1'b1; dwell_a = 4'd2;
        for (int k = 1; k <= 13; k++) begin
            step();
            check("scan2_ch", ch_a, 32'((k / 3) % 4));
            check("scan2_y", y_a, 32'((k / 3) % 4 + 1));
            check("scan2_wrap", wrap_a, (k == 12) ? 1 : 0);
        end

        // Back to ch 0 with cnt cleared, then dwell=0 scan.
        mode_a = 1'b0; sel_a = 2'd0;
        step();
        check("dw0_start_y", y_a, 1);
        mode_a = 1'b1; dwell_a = 4'd0;
        step();
        check("dw0_y1", y_a, 2);
        step();
        check("dw0_y2", y_a, 3);
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_y", y_a, 3);
            check("hold_ch", ch_a, 2);
            check("hold_wrap", wrap_a, 0);
        end
        en_a = 1'b1;
        step();
        check("resume_y", y_a, 4);
        step();
        check("dw0_wrap_y", y_a, 1);
        check("dw0_wrap", wrap_a, 1);
        en_a = 1'b0;
        step();
        check("wrap_not_stretched", wrap_a, 0);
        check("wrap_hold_y", y_a, 1);
        en_a = 1'b1;

        // Mode switch and data tracking.
        step();
        check("ms_scan_ch", ch_a, 1);
        mode_a = 1'b0; sel_a = 2'd3;
        step();
        check("ms_ch", ch_a, 3);
        check("ms_y", y_a, 4);
        din_a = {4'd14, 4'd3, 4'd2, 4'd1};
        step();
        check("track_y", y_a, 14);
        mode_a = 1'b1; dwell_a = 4'd1;
        step();
        check("ms2_ch_a", ch_a, 3);
        check("ms2_wrap_a", wrap_a, 0);
        step();
        check("ms2_ch_b", ch_a, 0);
        check("ms2_y_b", y_a, 1);
        check("ms2_wrap_b", wrap_a, 1);
        step();
        check("ms2_wrap_c", wrap_a, 0);

        // Three-channel instance.
        din_b = {4'd13, 4'd12, 4'd9};
        en_b = 1'b1; sel_b = 2'd1;
        step();
        check("b_sel1_y", y_b, 12);
        check("b_sel1_ch", ch_b, 1);
        sel_b = 2'd3;
        step();
        check("b_sel3_y", y_b, 12);
        check("b_sel3_ch", ch_b, 1);
        mode_b = 1'b1; dwell_b = 4'd0;
        step();
        check("b_scan_ch2", ch_b, 2);
        check("b_scan_wrap0", wrap_b, 0);
        step();
        check("b_scan_ch0", ch_b, 0);
        check("b_scan_y0", y_b, 9);
        check("b_scan_wrap1", wrap_b, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
